// File: rtl/mealy_seq_detector_param.sv
// Mealy serial sequence detector with a runtime-loadable N-bit pattern,
// selectable overlapping/non-overlapping detection and a saturating match counter.
module mealy_seq_detector_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PAT_RST = 4'b1011,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             ovl,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [N-1:0]     pat
);

    localparam int FW = (N > 1) ? $clog2(N) : 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

    logic [N-2:0]  hist;
    logic [FW-1:0] fill;
    logic [N-1:0]  hist_x;

    // Window of the last N-1 consumed bits plus the bit on x right now.
    // Its low N-1 bits are also the next history on any shifting cycle.
    assign hist_x = {hist, x};

    assign z = rst & en & ~pat_load & (fill == FILL_MAX) & (hist_x == pat);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; z is read here as a pure function of those values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pat       <= PAT_RST;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
        end else if (pat_load) begin
            pat       <= pat_in;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
        end else if (en) begin
            if (z) begin
                if (match_cnt != '1)
                    match_cnt <= match_cnt + 1'b1;
                if (ovl) begin
                    hist <= hist_x[N-2:0];
                end else begin
                    hist <= '0;
                    fill <= '0;
                end
            end else begin
                hist <= hist_x[N-2:0];
                if (fill != FILL_MAX)
                    fill <= fill + 1'b1;
            end
        end
    end

endmodule
